// File: rtl/rs_age_ordered_if.sv
// Port bundle for rs_age_ordered: instruction-queue load, CDB broadcast,
// branch resolution and execution-unit issue handshake.
`timescale 1ns/1ps
interface rs_age_ordered_if #(
  parameter int BW_DATA     = 32,
  parameter int NUM_OPERAND = 2,
  parameter int NUM_ENTRY   = 8,
  parameter int BW_TAG      = 4,
  parameter int NUM_CDB     = 2,
  parameter int NUM_BRANCH  = 4
);
  localparam int BW_CNT = $clog2(NUM_ENTRY + 1);

  logic                           i_iq_valid;
  logic                           i_iq_ready;
  logic [NUM_OPERAND*BW_TAG-1:0]  i_iq_Q_flatten;
  logic [NUM_OPERAND*BW_DATA-1:0] i_iq_V_flatten;
  logic [BW_TAG-1:0]              i_iq_tag;
  logic [NUM_BRANCH-1:0]          i_iq_brmask;
  logic                           i_branch_valid;
  logic [NUM_BRANCH-1:0]          i_branch_id;
  logic                           i_branch_correct;
  logic [NUM_CDB-1:0]             i_cdb_valid;
  logic [NUM_CDB*BW_TAG-1:0]      i_cdb_tag_flatten;
  logic [NUM_CDB*BW_DATA-1:0]     i_cdb_data_flatten;
  logic                           o_exe_valid;
  logic                           o_exe_ready;
  logic [BW_TAG-1:0]              o_exe_tag;
  logic [NUM_OPERAND*BW_DATA-1:0] o_exe_V_flatten;
  logic [BW_CNT-1:0]              o_occupancy;

  modport master (
    output i_iq_valid, i_iq_Q_flatten, i_iq_V_flatten, i_iq_tag, i_iq_brmask,
           i_branch_valid, i_branch_id, i_branch_correct,
           i_cdb_valid, i_cdb_tag_flatten, i_cdb_data_flatten, o_exe_ready,
    input  i_iq_ready, o_exe_valid, o_exe_tag, o_exe_V_flatten, o_occupancy
  );

  modport slave (
    input  i_iq_valid, i_iq_Q_flatten, i_iq_V_flatten, i_iq_tag, i_iq_brmask,
           i_branch_valid, i_branch_id, i_branch_correct,
           i_cdb_valid, i_cdb_tag_flatten, i_cdb_data_flatten, o_exe_ready,
    output i_iq_ready, o_exe_valid, o_exe_tag, o_exe_V_flatten, o_occupancy
  );
endinterface

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station with CDB wakeup, branch-mask speculation and issue lock.
// Optional RS_CDB_BYPASS_EN: entries woken by the CDB this cycle may issue with the CDB data.
`timescale 1ns/1ps
module rs_age_ordered #(
  parameter int BW_DATA     = 32,
  parameter int NUM_OPERAND = 2,
  parameter int NUM_ENTRY   = 8,
  parameter int BW_TAG      = 4,
  parameter int NUM_CDB     = 2,
  parameter int NUM_BRANCH  = 4
) (
  input logic           clk,
  input logic           rst_n,
  rs_age_ordered_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_ENTRY);
  localparam int BW_CNT = $clog2(NUM_ENTRY + 1);
  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_ENTRY-1:0]  valid_q, valid_d;
  // older_q[i][j] set means entry j was loaded before entry i
  logic [NUM_ENTRY-1:0]  older_q [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]  older_d [NUM_ENTRY];
  logic                  lock_valid_q, lock_valid_d;
  idx_t                  lock_idx_q, lock_idx_d;
  logic [BW_TAG-1:0]     tag_q [NUM_ENTRY];
  logic [BW_TAG-1:0]     tag_d [NUM_ENTRY];
  logic [NUM_BRANCH-1:0] brmask_q [NUM_ENTRY];
  logic [NUM_BRANCH-1:0] brmask_d [NUM_ENTRY];
  logic [BW_TAG-1:0]     src_tag_q [NUM_ENTRY][NUM_OPERAND];
  logic [BW_TAG-1:0]     src_tag_d [NUM_ENTRY][NUM_OPERAND];
  logic [BW_DATA-1:0]    src_val_q [NUM_ENTRY][NUM_OPERAND];
  logic [BW_DATA-1:0]    src_val_d [NUM_ENTRY][NUM_OPERAND];

  logic                  hit      [NUM_ENTRY][NUM_OPERAND];
  logic [BW_DATA-1:0]    hit_data [NUM_ENTRY][NUM_OPERAND];
  logic [NUM_ENTRY-1:0]  ready;
  idx_t                  oldest_idx, sel_idx, free_idx;
  logic                  any_ready, mispredict, correct_br, flush_sel;
  logic                  exe_valid, issue, iq_ready, load, load_flush;
  logic [NUM_BRANCH-1:0] in_mask;
  logic [BW_DATA:0]      in_look;
  logic [BW_CNT-1:0]     occupancy;

  // Returns {hit, data}; the lowest matching port wins, tag 0 never matches.
  function automatic logic [BW_DATA:0] cdb_lookup(
    input logic [BW_TAG-1:0]          tag,
    input logic [NUM_CDB-1:0]         vld,
    input logic [NUM_CDB*BW_TAG-1:0]  tags,
    input logic [NUM_CDB*BW_DATA-1:0] data
  );
    logic [BW_DATA:0] r;
    r = '0;
    if (tag != '0) begin
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (vld[p] && (tags[p*BW_TAG +: BW_TAG] == tag)) r = {1'b1, data[p*BW_DATA +: BW_DATA]};
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      for (int k = 0; k < NUM_OPERAND; k++) begin
        {hit[i][k], hit_data[i][k]} = cdb_lookup(src_tag_q[i][k], bus.i_cdb_valid,
                                                 bus.i_cdb_tag_flatten, bus.i_cdb_data_flatten);
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ready[i] = valid_q[i] && (brmask_q[i] == '0);
      for (int k = 0; k < NUM_OPERAND; k++) begin
`ifdef RS_CDB_BYPASS_EN
        if ((src_tag_q[i][k] != '0) && !hit[i][k]) ready[i] = 1'b0;
`else
        if (src_tag_q[i][k] != '0) ready[i] = 1'b0;
`endif
      end
    end
    oldest_idx = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (ready[i] && ((ready & older_q[i]) == '0)) oldest_idx = idx_t'(i);
    end
    free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = idx_t'(i);
    end
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRY; i++) occupancy = occupancy + BW_CNT'(valid_q[i]);

    any_ready  = |ready;
    sel_idx    = lock_valid_q ? lock_idx_q : oldest_idx;
    mispredict = bus.i_branch_valid && !bus.i_branch_correct;
    correct_br = bus.i_branch_valid && bus.i_branch_correct;
    // Defensive: a ready entry has an empty mask, but a flushed pick must never leave.
    flush_sel  = mispredict && ((brmask_q[sel_idx] & bus.i_branch_id) != '0);
    exe_valid  = (lock_valid_q || any_ready) && !flush_sel;
    issue      = exe_valid && bus.o_exe_ready;
    iq_ready   = ~&valid_q;
    load       = bus.i_iq_valid && iq_ready;
    load_flush = mispredict && ((bus.i_iq_brmask & bus.i_branch_id) != '0);
    in_mask    = correct_br ? (bus.i_iq_brmask & ~bus.i_branch_id) : bus.i_iq_brmask;

    bus.i_iq_ready      = iq_ready;
    bus.o_occupancy     = occupancy;
    bus.o_exe_valid     = exe_valid;
    bus.o_exe_tag       = exe_valid ? tag_q[sel_idx] : '0;
    bus.o_exe_V_flatten = '0;
    if (exe_valid) begin
      for (int k = 0; k < NUM_OPERAND; k++) begin
`ifdef RS_CDB_BYPASS_EN
        bus.o_exe_V_flatten[k*BW_DATA +: BW_DATA] = hit[sel_idx][k] ? hit_data[sel_idx][k]
                                                                    : src_val_q[sel_idx][k];
`else
        bus.o_exe_V_flatten[k*BW_DATA +: BW_DATA] = src_val_q[sel_idx][k];
`endif
      end
    end
  end

  always_comb begin
    valid_d      = valid_q;
    older_d      = older_q;
    tag_d        = tag_q;
    brmask_d     = brmask_q;
    src_tag_d    = src_tag_q;
    src_val_d    = src_val_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    in_look      = '0;

    for (int i = 0; i < NUM_ENTRY; i++) begin
      for (int k = 0; k < NUM_OPERAND; k++) begin
        if (hit[i][k]) begin
          src_tag_d[i][k] = '0;
          src_val_d[i][k] = hit_data[i][k];
        end
      end
      if (correct_br) brmask_d[i] = brmask_q[i] & ~bus.i_branch_id;
      if (mispredict && ((brmask_q[i] & bus.i_branch_id) != '0)) valid_d[i] = 1'b0;
    end

    if (issue) valid_d[sel_idx] = 1'b0;

    // A flushed incoming instruction still handshakes; it is simply dropped.
    if (load && !load_flush) begin
      valid_d[free_idx]  = 1'b1;
      tag_d[free_idx]    = bus.i_iq_tag;
      brmask_d[free_idx] = in_mask;
      older_d[free_idx]  = valid_q;
      for (int j = 0; j < NUM_ENTRY; j++) older_d[j][free_idx] = 1'b0;
      for (int k = 0; k < NUM_OPERAND; k++) begin
        in_look = cdb_lookup(bus.i_iq_Q_flatten[k*BW_TAG +: BW_TAG], bus.i_cdb_valid,
                             bus.i_cdb_tag_flatten, bus.i_cdb_data_flatten);
        src_tag_d[free_idx][k] = in_look[BW_DATA] ? '0 : bus.i_iq_Q_flatten[k*BW_TAG +: BW_TAG];
        src_val_d[free_idx][k] = in_look[BW_DATA] ? in_look[BW_DATA-1:0]
                                                  : bus.i_iq_V_flatten[k*BW_DATA +: BW_DATA];
      end
    end

    if (flush_sel || issue) begin
      lock_valid_d = 1'b0;
    end else if (exe_valid) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) older_q[i] <= '0;
    end else begin
      valid_q      <= valid_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      older_q      <= older_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q     <= tag_d;
    brmask_q  <= brmask_d;
    src_tag_q <= src_tag_d;
    src_val_q <= src_val_d;
  end
endmodule

// File: tb/tb_rs_age_ordered.sv
// Self-checking bench for rs_age_ordered: vector table for fill/full behaviour,
// directed sequences for wakeup, hold, branch flush; issues checked by a scoreboard.
`timescale 1ns/1ps
module tb_rs_age_ordered;
  localparam int BW_DATA = 32, NUM_OPERAND = 2, NUM_ENTRY = 8;
  localparam int BW_TAG = 4, NUM_CDB = 2, NUM_BRANCH = 4;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_age_ordered_if #(.BW_DATA(BW_DATA), .NUM_OPERAND(NUM_OPERAND), .NUM_ENTRY(NUM_ENTRY),
                      .BW_TAG(BW_TAG), .NUM_CDB(NUM_CDB), .NUM_BRANCH(NUM_BRANCH)) bus ();

  rs_age_ordered #(.BW_DATA(BW_DATA), .NUM_OPERAND(NUM_OPERAND), .NUM_ENTRY(NUM_ENTRY),
                   .BW_TAG(BW_TAG), .NUM_CDB(NUM_CDB), .NUM_BRANCH(NUM_BRANCH))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [3:0] tag; logic [31:0] v0; logic [31:0] v1; } exp_t;
  typedef struct {
    logic       iq_valid;
    logic [3:0] tag;
    logic       e_iq_ready;
    logic [3:0] e_occ;
    logic       e_valid;
    logic [3:0] e_tag;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] tag, input logic [31:0] v0, input logic [31:0] v1);
    exp_t e;
    e.tag = tag; e.v0 = v0; e.v1 = v1;
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (bus.o_exe_valid && bus.o_exe_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_issue: got tag 0x%0h, expected no issue", bus.o_exe_tag);
      end else begin
        e = sb.pop_front();
        chk("issue_tag", 64'(bus.o_exe_tag), 64'(e.tag));
        chk("issue_v0", 64'(bus.o_exe_V_flatten[31:0]), 64'(e.v0));
        chk("issue_v1", 64'(bus.o_exe_V_flatten[63:32]), 64'(e.v1));
      end
    end
  endtask

  task automatic set_idle();
    bus.i_iq_valid = 1'b0; bus.i_iq_Q_flatten = '0; bus.i_iq_V_flatten = '0;
    bus.i_iq_tag = '0; bus.i_iq_brmask = '0;
    bus.i_cdb_valid = '0; bus.i_cdb_tag_flatten = '0; bus.i_cdb_data_flatten = '0;
    bus.i_branch_valid = 1'b0; bus.i_branch_id = '0; bus.i_branch_correct = 1'b0;
  endtask

  task automatic load_in(input logic [3:0] tag, input logic [3:0] q0, input logic [31:0] v0,
                         input logic [3:0] q1, input logic [31:0] v1, input logic [3:0] mask);
    bus.i_iq_valid = 1'b1; bus.i_iq_tag = tag; bus.i_iq_brmask = mask;
    bus.i_iq_Q_flatten = {q1, q0}; bus.i_iq_V_flatten = {v1, v0};
  endtask

  task automatic cdb(input int port, input logic [3:0] tag, input logic [31:0] data);
    bus.i_cdb_valid[port] = 1'b1;
    bus.i_cdb_tag_flatten[port*BW_TAG +: BW_TAG] = tag;
    bus.i_cdb_data_flatten[port*BW_DATA +: BW_DATA] = data;
  endtask

  task automatic branch(input logic [3:0] id, input logic correct);
    bus.i_branch_valid = 1'b1; bus.i_branch_id = id; bus.i_branch_correct = correct;
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic drain(input int budget);
    bus.o_exe_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() > 0; i++) cyc();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      vecs[i].iq_valid   = (i < 9);
      vecs[i].tag        = 4'(i + 1);
      vecs[i].e_iq_ready = (i < 8);
      vecs[i].e_occ      = 4'((i < 8) ? i : 8);
      vecs[i].e_valid    = (i > 0);
      vecs[i].e_tag      = (i > 0) ? 4'd1 : 4'd0;
    end

    set_idle();
    bus.o_exe_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_exe_valid", 64'(bus.o_exe_valid), 64'd0);
    chk("rst_exe_tag", 64'(bus.o_exe_tag), 64'd0);
    chk("rst_exe_v", 64'(bus.o_exe_V_flatten), 64'd0);
    chk("rst_occupancy", 64'(bus.o_occupancy), 64'd0);
    chk("rst_iq_ready", 64'(bus.i_iq_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill to capacity with ready entries while the execution unit stalls.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].iq_valid)
        load_in(vecs[i].tag, 4'd0, 32'(vecs[i].tag) << 8, 4'd0, 32'(vecs[i].tag), 4'd0);
      if (vecs[i].e_iq_ready)
        sb_push(vecs[i].tag, 32'(vecs[i].tag) << 8, 32'(vecs[i].tag));
      sample();
      chk("fill_iq_ready", 64'(bus.i_iq_ready), 64'(vecs[i].e_iq_ready));
      chk("fill_occupancy", 64'(bus.o_occupancy), 64'(vecs[i].e_occ));
      chk("fill_exe_valid", 64'(bus.o_exe_valid), 64'(vecs[i].e_valid));
      chk("fill_exe_tag", 64'(bus.o_exe_tag), 64'(vecs[i].e_tag));
      adv();
    end
    drain(30);

    // Wakeup order: C (older, slot 2) beats D (younger, reused slot 1).
    bus.o_exe_ready = 1'b1;
    load_in(4'd10, 4'd5, 32'h0, 4'd0, 32'h77, 4'd0);
    sample(); chk("t2_a_load_valid", 64'(bus.o_exe_valid), 64'd0); adv();
    load_in(4'd11, 4'd0, 32'hB0, 4'd0, 32'hB1, 4'd0); sb_push(4'd11, 32'hB0, 32'hB1);
    sample(); chk("t2_b_load_valid", 64'(bus.o_exe_valid), 64'd0); adv();
    load_in(4'd12, 4'd6, 32'h0, 4'd0, 32'hC1, 4'd0); sb_push(4'd12, 32'h66, 32'hC1);
    sample(); chk("t2_b_presented", 64'(bus.o_exe_tag), 64'd11); adv();
    load_in(4'd13, 4'd6, 32'h0, 4'd0, 32'hD1, 4'd0); sb_push(4'd13, 32'h66, 32'hD1);
    sample(); chk("t2_waiting_valid", 64'(bus.o_exe_valid), 64'd0); adv();
    cdb(0, 4'd6, 32'h66);
    sample(); chk("t2_bcast6_valid", 64'(bus.o_exe_valid), 64'(BYP)); adv();
    cyc();
    cyc();
    sb_push(4'd10, 32'h1234, 32'h77);
    cdb(0, 4'd5, 32'h1234);
    sample(); chk("t2_bcast5_valid", 64'(bus.o_exe_valid), 64'(BYP)); adv();
    drain(10);

    // Hold: locked B stays presented after older A wakes up.
    bus.o_exe_ready = 1'b0;
    load_in(4'd14, 4'd7, 32'h0, 4'd0, 32'hE1, 4'd0); cyc();
    load_in(4'd15, 4'd0, 32'hF0, 4'd0, 32'hF1, 4'd0); cyc();
    sb_push(4'd15, 32'hF0, 32'hF1);
    sb_push(4'd14, 32'h70, 32'hE1);
    sample(); chk("t3_present_b", 64'(bus.o_exe_tag), 64'd15); adv();
    cdb(1, 4'd7, 32'h70);
    sample(); chk("t3_hold_bcast", 64'(bus.o_exe_tag), 64'd15); adv();
    sample(); chk("t3_hold_after", 64'(bus.o_exe_tag), 64'd15); adv();
    drain(10);

    // Branch masks: mispredict flushes E and the incoming H, correct frees F.
    bus.o_exe_ready = 1'b0;
    load_in(4'd1, 4'd0, 32'h10, 4'd0, 32'h11, 4'b0001); cyc();
    load_in(4'd2, 4'd0, 32'h20, 4'd0, 32'h21, 4'b0010); cyc();
    load_in(4'd3, 4'd0, 32'h30, 4'd0, 32'h31, 4'b0000);
    sample(); chk("t4_spec_not_ready", 64'(bus.o_exe_valid), 64'd0); adv();
    sample();
    chk("t4_occ3", 64'(bus.o_occupancy), 64'd3);
    chk("t4_g_tag", 64'(bus.o_exe_tag), 64'd3);
    adv();
    branch(4'b0001, 1'b0);
    load_in(4'd4, 4'd0, 32'h40, 4'd0, 32'h41, 4'b0001);
    sample();
    chk("t4_flush_keeps_g", 64'(bus.o_exe_tag), 64'd3);
    chk("t4_iq_ready_flush", 64'(bus.i_iq_ready), 64'd1);
    adv();
    branch(4'b0010, 1'b1);
    sample(); chk("t4_occ_after_flush", 64'(bus.o_occupancy), 64'd2); adv();
    sample(); chk("t4_lock_holds_g", 64'(bus.o_exe_tag), 64'd3); adv();
    sb_push(4'd3, 32'h30, 32'h31);
    sb_push(4'd2, 32'h20, 32'h21);
    drain(10);
    sample(); chk("t4_empty", 64'(bus.o_occupancy), 64'd0); adv();

    // Two ports matching the same tag: port 0 wins; then load-cycle wakeup.
    bus.o_exe_ready = 1'b1;
    load_in(4'd5, 4'd3, 32'h0, 4'd0, 32'h51, 4'd0); sb_push(4'd5, 32'hA, 32'h51);
    sample(); chk("t5_load_valid", 64'(bus.o_exe_valid), 64'd0); adv();
    cdb(0, 4'd3, 32'hA); cdb(1, 4'd3, 32'hB);
    sample(); chk("t5_bcast_valid", 64'(bus.o_exe_valid), 64'(BYP)); adv();
    load_in(4'd6, 4'd9, 32'h0, 4'd0, 32'h61, 4'd0); cdb(1, 4'd9, 32'h99);
    sb_push(4'd6, 32'h99, 32'h61);
    cyc();
    drain(10);

    // Speculative entry flushed while the execution unit is ready.
    load_in(4'd7, 4'd0, 32'h70, 4'd0, 32'h71, 4'b0001); cyc();
    branch(4'b0001, 1'b0);
    sample();
    chk("t6_flush_valid", 64'(bus.o_exe_valid), 64'd0);
    chk("t6_occ_before", 64'(bus.o_occupancy), 64'd1);
    adv();
    sample();
    chk("t6_occ_after", 64'(bus.o_occupancy), 64'd0);
    chk("t6_valid_after", 64'(bus.o_exe_valid), 64'd0);
    adv();

    // Correct resolution in the load cycle clears the incoming mask bit.
    load_in(4'd8, 4'd0, 32'h80, 4'd0, 32'h81, 4'b1000); branch(4'b1000, 1'b1);
    sb_push(4'd8, 32'h80, 32'h81);
    cyc();
    sample(); chk("t7_ready_next", 64'(bus.o_exe_valid), 64'd1); adv();
    sample(); chk("t7_occ", 64'(bus.o_occupancy), 64'd0); adv();

    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
